// File: rtl/dc_mem_ctrl_pkg.sv
// Shared widths, request length codes and FSM encoding for the data-side memory controller.
package dc_mem_ctrl_pkg;

  localparam int DAT_W     = 32;
  localparam int RAM_ADR_W = 17;

  localparam logic [2:0] LEN_B = 3'd1;
  localparam logic [2:0] LEN_H = 3'd2;
  localparam logic [2:0] LEN_W = 3'd4;

  typedef enum logic [2:0] {
    DC_IDLE  = 3'd0,
    DC_READ  = 3'd1,
    DC_RLAST = 3'd2,
    DC_WRITE = 3'd3,
    DC_DONE  = 3'd4
  } dc_state_e;

  // Index of the last byte of a request; anything that is not B or H is a word.
  function automatic logic [1:0] len_last(input logic [2:0] len);
    logic [1:0] last;
    case (len)
      LEN_B:   last = 2'd0;
      LEN_H:   last = 2'd1;
      LEN_W:   last = 2'd3;
      default: last = 2'd3;
    endcase
    return last;
  endfunction

endpackage

// File: rtl/dc_mem_ctrl.sv
// Data-side memory controller: serialises one LSB load/store into byte accesses
// on an 8-bit synchronous RAM; loads return zero-extended little-endian data.
module dc_mem_ctrl
  import dc_mem_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 lsb_en_i,
  input  logic                 lsb_rwen_i,
  input  logic [2:0]           lsb_len_i,
  input  logic [RAM_ADR_W-1:0] lsb_adr_i,
  input  logic [DAT_W-1:0]     lsb_dat_i,
  output logic                 lsb_en_o,
  output logic [DAT_W-1:0]     lsb_dat_o,
  output logic                 busy_o,
  input  logic [7:0]           ram_dat_i,
  output logic [7:0]           ram_dat_o,
  output logic [RAM_ADR_W-1:0] ram_adr_o,
  output logic                 ram_wr_o,
  input  logic                 rob_br_flag
);

  dc_state_e            state_r, state_s;
  logic                 rwen_r, rwen_s;
  logic [1:0]           last_r, last_s;
  logic [1:0]           cnt_r, cnt_s;
  logic [1:0]           cnt_inc_s;
  logic [1:0]           rd_lane_s;
  logic [RAM_ADR_W-1:0] adr_r, adr_s;
  logic [DAT_W-1:0]     dat_r, dat_s;
  logic [DAT_W-1:0]     asm_r, asm_s;
  logic [DAT_W-1:0]     rd_word_s;
  logic                 lsb_en_r, lsb_en_s;
  logic [DAT_W-1:0]     lsb_dat_r, lsb_dat_s;
  logic                 busy_r;
  logic [7:0]           ram_dat_r, ram_dat_s;
  logic [RAM_ADR_W-1:0] ram_adr_r, ram_adr_s;
  logic                 ram_wr_r, ram_wr_s;

  // Byte lane for the incoming read byte: lags the address counter by one cycle.
  always_comb begin
    cnt_inc_s = cnt_r + 2'd1;
    if (state_r == DC_RLAST) begin
      rd_lane_s = last_r;
    end else begin
      rd_lane_s = cnt_r - 2'd1;
    end
    rd_word_s = DAT_W'(ram_dat_i) << {rd_lane_s, 3'b000};
  end

  // Next-state and next-output logic; RAM outputs are registered one step ahead.
  always_comb begin
    state_s   = state_r;
    rwen_s    = rwen_r;
    last_s    = last_r;
    cnt_s     = cnt_r;
    adr_s     = adr_r;
    dat_s     = dat_r;
    asm_s     = asm_r;
    lsb_en_s  = 1'b0;
    lsb_dat_s = lsb_dat_r;
    ram_dat_s = ram_dat_r;
    ram_adr_s = ram_adr_r;
    ram_wr_s  = 1'b0;

    case (state_r)
      DC_IDLE: begin
        // A load colliding with a flush belongs to the squashed path; a store is committed.
        if (lsb_en_i && (lsb_rwen_i || !rob_br_flag)) begin
          rwen_s    = lsb_rwen_i;
          last_s    = len_last(lsb_len_i);
          cnt_s     = 2'd0;
          adr_s     = lsb_adr_i;
          dat_s     = lsb_dat_i;
          asm_s     = '0;
          ram_adr_s = lsb_adr_i;
          if (lsb_rwen_i) begin
            state_s   = DC_WRITE;
            ram_wr_s  = 1'b1;
            ram_dat_s = lsb_dat_i[7:0];
          end else begin
            state_s   = DC_READ;
          end
        end else begin
          state_s = DC_IDLE;
        end
      end

      DC_READ: begin
        if (rob_br_flag) begin
          state_s = DC_IDLE;
        end else begin
          if (cnt_r != 2'd0) begin
            asm_s = asm_r | rd_word_s;
          end else begin
            asm_s = asm_r;
          end
          if (cnt_r == last_r) begin
            state_s = DC_RLAST;
          end else begin
            cnt_s     = cnt_inc_s;
            ram_adr_s = adr_r + RAM_ADR_W'(cnt_inc_s);
          end
        end
      end

      DC_RLAST: begin
        if (rob_br_flag) begin
          state_s = DC_IDLE;
        end else begin
          asm_s     = asm_r | rd_word_s;
          lsb_dat_s = asm_r | rd_word_s;
          lsb_en_s  = 1'b1;
          state_s   = DC_DONE;
        end
      end

      DC_WRITE: begin
        if (cnt_r == last_r) begin
          lsb_en_s = 1'b1;
          state_s  = DC_DONE;
        end else begin
          cnt_s     = cnt_inc_s;
          ram_wr_s  = 1'b1;
          ram_adr_s = adr_r + RAM_ADR_W'(cnt_inc_s);
          ram_dat_s = dat_r[{cnt_inc_s, 3'b000} +: 8];
        end
      end

      // A flush here only suppresses the load's done pulse at the output.
      DC_DONE: begin
        state_s = DC_IDLE;
      end

      default: begin
        state_s = DC_IDLE;
      end
    endcase
  end

  // FSM state register; frozen while the global ready is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= DC_IDLE;
    end else if (en) begin
      state_r <= state_s;
    end else begin
      state_r <= state_r;
    end
  end

  // Latched request, byte counter, assembly register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      rwen_r    <= 1'b0;
      last_r    <= 2'd0;
      cnt_r     <= 2'd0;
      adr_r     <= '0;
      dat_r     <= '0;
      asm_r     <= '0;
      lsb_en_r  <= 1'b0;
      lsb_dat_r <= '0;
      busy_r    <= 1'b0;
      ram_dat_r <= 8'h00;
      ram_adr_r <= '0;
      ram_wr_r  <= 1'b0;
    end else if (en) begin
      rwen_r    <= rwen_s;
      last_r    <= last_s;
      cnt_r     <= cnt_s;
      adr_r     <= adr_s;
      dat_r     <= dat_s;
      asm_r     <= asm_s;
      lsb_en_r  <= lsb_en_s;
      lsb_dat_r <= lsb_dat_s;
      busy_r    <= (state_s != DC_IDLE);
      ram_dat_r <= ram_dat_s;
      ram_adr_r <= ram_adr_s;
      ram_wr_r  <= ram_wr_s;
    end else begin
      rwen_r    <= rwen_r;
      last_r    <= last_r;
      cnt_r     <= cnt_r;
      adr_r     <= adr_r;
      dat_r     <= dat_r;
      asm_r     <= asm_r;
      lsb_en_r  <= lsb_en_r;
      lsb_dat_r <= lsb_dat_r;
      busy_r    <= busy_r;
      ram_dat_r <= ram_dat_r;
      ram_adr_r <= ram_adr_r;
      ram_wr_r  <= ram_wr_r;
    end
  end

  // Write strobe is cut immediately by a stall or reset so no stray byte lands.
  assign ram_wr_o  = ram_wr_r & en & ~rst;
  assign lsb_en_o  = lsb_en_r & ~(rob_br_flag & ~rwen_r);
  assign lsb_dat_o = lsb_dat_r;
  assign busy_o    = busy_r;
  assign ram_adr_o = ram_adr_r;
  assign ram_dat_o = ram_dat_r;

endmodule

// File: tb/tb_dc_mem_ctrl.sv
// Self-checking bench for dc_mem_ctrl with a byte RAM model and load/store scoreboards.
module tb_dc_mem_ctrl;
  import dc_mem_ctrl_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst, en, lsb_en_i, lsb_rwen_i, rob_br_flag;
  logic [2:0]           lsb_len_i;
  logic [RAM_ADR_W-1:0] lsb_adr_i;
  logic [DAT_W-1:0]     lsb_dat_i;
  logic                 lsb_en_o, busy_o, ram_wr_o;
  logic [DAT_W-1:0]     lsb_dat_o;
  logic [7:0]           ram_dat_i, ram_dat_o;
  logic [RAM_ADR_W-1:0] ram_adr_o;

  logic [7:0]           mem [0:(1<<RAM_ADR_W)-1];
  logic                 bd_we;
  logic [RAM_ADR_W-1:0] bd_adr;
  logic [7:0]           bd_dat;

  typedef struct {
    logic [RAM_ADR_W-1:0] adr;
    logic [7:0]           dat;
    int                   cyc;
  } wr_t;

  wr_t              wq[$];
  logic [DAT_W-1:0] rq[$];
  int               n_checks = 0;
  int               n_pass   = 0;

  always #5 clk = ~clk;

  dc_mem_ctrl dut (
    .clk(clk), .rst(rst), .en(en),
    .lsb_en_i(lsb_en_i), .lsb_rwen_i(lsb_rwen_i), .lsb_len_i(lsb_len_i),
    .lsb_adr_i(lsb_adr_i), .lsb_dat_i(lsb_dat_i),
    .lsb_en_o(lsb_en_o), .lsb_dat_o(lsb_dat_o), .busy_o(busy_o),
    .ram_dat_i(ram_dat_i), .ram_dat_o(ram_dat_o), .ram_adr_o(ram_adr_o),
    .ram_wr_o(ram_wr_o), .rob_br_flag(rob_br_flag)
  );

  // Synchronous RAM; like the rest of the system it is frozen while en is low.
  always @(posedge clk) begin
    if (en) begin
      ram_dat_i <= mem[ram_adr_o];
      if (ram_wr_o) mem[ram_adr_o] <= ram_dat_o;
    end
    if (bd_we) mem[bd_adr] <= bd_dat;
  end

  function automatic int leff_of(input logic [2:0] len);
    if (len == 3'd1) return 1;
    else if (len == 3'd2) return 2;
    else return 4;
  endfunction

  task automatic poke(input logic [RAM_ADR_W-1:0] a, input logic [7:0] d);
    bd_we = 1'b1; bd_adr = a; bd_dat = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  // Drives a request in cycle 0 and returns at the falling edge of cycle 1.
  task automatic issue(input logic rw, input logic [2:0] len, input logic [RAM_ADR_W-1:0] a,
                       input logic [DAT_W-1:0] d, input logic fl);
    lsb_en_i = 1'b1; lsb_rwen_i = rw; lsb_len_i = len; lsb_adr_i = a; lsb_dat_i = d;
    rob_br_flag = fl;
    @(negedge clk);
    lsb_en_i = 1'b0; rob_br_flag = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (lsb_en_o !== 1'b0) $display("FAIL reset lsb_en_o got %b want 0", lsb_en_o); else n_pass++;
    n_checks++; if (lsb_dat_o !== 32'h0) $display("FAIL reset lsb_dat_o got %h want 0", lsb_dat_o); else n_pass++;
    n_checks++; if (busy_o !== 1'b0) $display("FAIL reset busy_o got %b want 0", busy_o); else n_pass++;
    n_checks++; if (ram_wr_o !== 1'b0) $display("FAIL reset ram_wr_o got %b want 0", ram_wr_o); else n_pass++;
    n_checks++; if (ram_adr_o !== 17'h0) $display("FAIL reset ram_adr_o got %h want 0", ram_adr_o); else n_pass++;
    n_checks++; if (ram_dat_o !== 8'h0) $display("FAIL reset ram_dat_o got %h want 0", ram_dat_o); else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (busy_o !== 1'b0) $display("FAIL post_reset busy_o got %b want 0", busy_o); else n_pass++;
  endtask

  // Load with optional flush cycle and optional stall window [st_a, st_b].
  task automatic test_load(input string nm, input logic [2:0] len, input logic [RAM_ADR_W-1:0] a,
                           input int flush_c, input int st_a, input int st_b);
    int le, e;
    bit fl, seen;
    logic [DAT_W-1:0] exp;
    logic [RAM_ADR_W-1:0] ea;
    le = leff_of(len);
    exp = '0;
    for (int i = 0; i < le; i++) begin
      ea = a + RAM_ADR_W'(i);
      exp = exp | (DAT_W'(mem[ea]) << (8 * i));
    end
    if (flush_c == 0) rq.push_back(exp);
    issue(1'b0, len, a, 32'h0, 1'b0);
    e = 1; fl = 1'b0; seen = 1'b0;
    for (int c = 1; c <= 40 && e <= le + 3; c++) begin
      en = (c >= st_a && c <= st_b) ? 1'b0 : 1'b1;
      rob_br_flag = (c == flush_c) ? 1'b1 : 1'b0;
      #1;
      if (fl) begin
        n_checks++;
        if (busy_o !== 1'b0 || lsb_en_o !== 1'b0)
          $display("FAIL %s flushed c%0d busy/en got %b%b want 00", nm, c, busy_o, lsb_en_o);
        else n_pass++;
      end else begin
        if (e <= le) begin
          ea = a + RAM_ADR_W'(e - 1);
          n_checks++;
          if (ram_adr_o !== ea) $display("FAIL %s adr c%0d got %h want %h", nm, c, ram_adr_o, ea);
          else n_pass++;
        end
        n_checks++;
        if (busy_o !== (e <= le + 2)) $display("FAIL %s busy c%0d got %b want %b", nm, c, busy_o, e <= le + 2);
        else n_pass++;
        n_checks++;
        if (lsb_en_o !== (e == le + 2)) $display("FAIL %s lsb_en c%0d got %b want %b", nm, c, lsb_en_o, e == le + 2);
        else n_pass++;
        if (lsb_en_o === 1'b1) begin
          n_checks++;
          if (rq.size() == 0) $display("FAIL %s unexpected done c%0d got %h want none", nm, c, lsb_dat_o);
          else begin
            exp = rq.pop_front();
            seen = 1'b1;
            if (lsb_dat_o !== exp) $display("FAIL %s data got %h want %h", nm, lsb_dat_o, exp);
            else n_pass++;
          end
        end
      end
      if (c == flush_c) fl = 1'b1;
      if (en) e++;
      @(negedge clk);
    end
    en = 1'b1; rob_br_flag = 1'b0;
    n_checks++;
    if (seen !== (flush_c == 0)) $display("FAIL %s done_seen got %b want %b", nm, seen, flush_c == 0);
    else n_pass++;
  endtask

  // Store with optional flush cycle and optional reset cycle; checks RAM afterwards.
  task automatic test_store(input string nm, input logic [2:0] len, input logic [RAM_ADR_W-1:0] a,
                            input logic [DAT_W-1:0] d, input int flush_c, input int rst_c);
    int le;
    wr_t w;
    logic [7:0] want;
    logic [RAM_ADR_W-1:0] ea;
    le = leff_of(len);
    for (int i = 0; i <= le; i++) poke(a + RAM_ADR_W'(i), 8'h5A ^ 8'(i));
    for (int i = 0; i < le; i++)
      if (rst_c == 0 || i + 1 < rst_c) wq.push_back('{a + RAM_ADR_W'(i), d[8*i +: 8], i + 1});
    issue(1'b1, len, a, d, 1'b0);
    for (int c = 1; c <= le + 2; c++) begin
      rob_br_flag = (c == flush_c) ? 1'b1 : 1'b0;
      rst = (c == rst_c) ? 1'b1 : 1'b0;
      #1;
      if (rst_c != 0 && c >= rst_c) begin
        n_checks++;
        if (ram_wr_o !== 1'b0) $display("FAIL %s rst ram_wr c%0d got %b want 0", nm, c, ram_wr_o); else n_pass++;
        if (c > rst_c) begin
          n_checks++;
          if (busy_o !== 1'b0) $display("FAIL %s rst busy c%0d got %b want 0", nm, c, busy_o); else n_pass++;
        end
      end else begin
        n_checks++;
        if (ram_wr_o !== (c <= le)) $display("FAIL %s ram_wr c%0d got %b want %b", nm, c, ram_wr_o, c <= le);
        else n_pass++;
        n_checks++;
        if (lsb_en_o !== (c == le + 1)) $display("FAIL %s ack c%0d got %b want %b", nm, c, lsb_en_o, c == le + 1);
        else n_pass++;
        n_checks++;
        if (busy_o !== (c <= le + 1)) $display("FAIL %s busy c%0d got %b want %b", nm, c, busy_o, c <= le + 1);
        else n_pass++;
        if (ram_wr_o === 1'b1) begin
          n_checks++;
          if (wq.size() == 0) $display("FAIL %s extra write c%0d got %h@%h want none", nm, c, ram_dat_o, ram_adr_o);
          else begin
            w = wq.pop_front();
            if (ram_adr_o !== w.adr || ram_dat_o !== w.dat || c != w.cyc)
              $display("FAIL %s write c%0d got %h@%h want %h@%h c%0d", nm, c, ram_dat_o, ram_adr_o, w.dat, w.adr, w.cyc);
            else n_pass++;
          end
        end
      end
      @(negedge clk);
    end
    rst = 1'b0; rob_br_flag = 1'b0;
    n_checks++;
    if (wq.size() != 0) $display("FAIL %s missing writes got %0d left want 0", nm, wq.size()); else n_pass++;
    wq.delete();
    for (int i = 0; i <= le; i++) begin
      ea = a + RAM_ADR_W'(i);
      want = (i < le && (rst_c == 0 || i + 1 < rst_c)) ? d[8*i +: 8] : (8'h5A ^ 8'(i));
      n_checks++;
      if (mem[ea] !== want) $display("FAIL %s ram[%h] got %h want %h", nm, ea, mem[ea], want); else n_pass++;
    end
  endtask

  task automatic test_request_flush();
    issue(1'b0, 3'd1, 17'h00100, 32'h0, 1'b1);
    #1;
    n_checks++;
    if (busy_o !== 1'b0) $display("FAIL req_flush load busy got %b want 0", busy_o); else n_pass++;
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if (lsb_en_o !== 1'b0) $display("FAIL req_flush load lsb_en got %b want 0", lsb_en_o); else n_pass++;
      @(negedge clk);
      #1;
    end
    issue(1'b1, 3'd1, 17'h00400, 32'h00000077, 1'b1);
    #1;
    n_checks++;
    if (busy_o !== 1'b1 || ram_wr_o !== 1'b1 || ram_adr_o !== 17'h00400 || ram_dat_o !== 8'h77)
      $display("FAIL req_flush store got %b%b %h@%h want 11 77@00400", busy_o, ram_wr_o, ram_dat_o, ram_adr_o);
    else n_pass++;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int c;
    logic [DAT_W-1:0] exp;
    poke(17'h00500, 8'h11);
    poke(17'h00501, 8'h22);
    rq.push_back(32'h00000011);
    issue(1'b0, 3'd1, 17'h00500, 32'h0, 1'b0);
    c = 1; #1;
    while (busy_o === 1'b1 && c < 20) begin
      if (lsb_en_o === 1'b1) begin
        n_checks++;
        if (rq.size() == 0) $display("FAIL b2b unexpected done got %h want none", lsb_dat_o);
        else begin
          exp = rq.pop_front();
          if (lsb_dat_o !== exp) $display("FAIL b2b lb data got %h want %h", lsb_dat_o, exp); else n_pass++;
        end
      end
      @(negedge clk); #1; c++;
    end
    n_checks++;
    if (c != 4) $display("FAIL b2b load interval got %0d want 4", c); else n_pass++;
    n_checks++;
    if (rq.size() != 0) $display("FAIL b2b load done missing got %0d left want 0", rq.size()); else n_pass++;
    rq.delete();
    issue(1'b1, 3'd1, 17'h00501, 32'h00000099, 1'b0);
    c = 1; #1;
    while (busy_o === 1'b1 && c < 20) begin
      @(negedge clk); #1; c++;
    end
    n_checks++;
    if (c != 3) $display("FAIL b2b store interval got %0d want 3", c); else n_pass++;
    test_load("b2b_lh", 3'd2, 17'h00500, 0, 0, -1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; en = 1'b1; lsb_en_i = 1'b0; lsb_rwen_i = 1'b0; lsb_len_i = 3'd0;
    lsb_adr_i = '0; lsb_dat_i = '0; rob_br_flag = 1'b0; bd_we = 1'b0; bd_adr = '0; bd_dat = 8'h00;
    @(negedge clk);
    test_reset();
    poke(17'h00100, 8'h78); poke(17'h00101, 8'h56); poke(17'h00102, 8'h34); poke(17'h00103, 8'h12);
    test_load("lw", 3'd4, 17'h00100, 0, 0, -1);
    test_store("sh", 3'd2, 17'h00201, 32'hDEADBEEF, 0, 0);
    poke(17'h1FFFF, 8'h80); poke(17'h00000, 8'h3C);
    test_load("lb_top", 3'd1, 17'h1FFFF, 0, 0, -1);
    test_load("lh_wrap", 3'd2, 17'h1FFFF, 0, 0, -1);
    test_load("lw_flush", 3'd4, 17'h00100, 2, 0, -1);
    test_store("sw_flush", 3'd4, 17'h00300, 32'hCAFEF00D, 2, 0);
    test_load("lw_stall", 3'd4, 17'h00100, 0, 2, 3);
    test_store("sw_rst", 3'd4, 17'h00380, 32'h0BADF00D, 0, 2);
    test_request_flush();
    test_back_to_back();
    test_load("len3_as_w", 3'd3, 17'h00100, 0, 0, -1);
    test_store("len0_as_w", 3'd0, 17'h00600, 32'h44332211, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
